// File: rtl/scr1_memif_pkg.sv
// scr1_memif_pkg -- memory interface types shared by the dmem router and
// its targets.
//   Contents: data/address widths plus the command, access width and
//   response encodings used on the router-to-target request/response path.
package scr1_memif_pkg;

  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  // NOTRDY doubles as the idle response: nothing is being answered
  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

endpackage : scr1_memif_pkg

// File: rtl/scr1_mtimer_pkg.sv
// scr1_mtimer_pkg -- constants for the multi-channel machine timer.
//   Contents: register offsets within the timer's 256-byte window, the
//   largest supported number of compare channels and the CTRL enable bit.
package scr1_mtimer_pkg;

  localparam logic [7:0] SCR1_MTIMER_OFS_CTRL     = 8'h00;
  localparam logic [7:0] SCR1_MTIMER_OFS_DIV      = 8'h04;
  localparam logic [7:0] SCR1_MTIMER_OFS_MTIME_LO = 8'h08;
  localparam logic [7:0] SCR1_MTIMER_OFS_MTIME_HI = 8'h0C;
  // channel i occupies CMP_BASE+8*i (low word) and CMP_BASE+8*i+4 (high word)
  localparam logic [7:0] SCR1_MTIMER_OFS_CMP_BASE = 8'h10;

  localparam int SCR1_MTIMER_CH_MAX  = 8;
  localparam int SCR1_MTIMER_CTRL_EN = 0;

endpackage : scr1_mtimer_pkg

// File: rtl/scr1_mtimer_cmp.sv
// scr1_mtimer_cmp -- one compare channel of the machine timer.
//   Holds a 64-bit mtimecmp register and the registered interrupt flag.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     wr_lo, wr_hi    load the low / high half of mtimecmp from wdata
//     wdata           write data from the bus
//     mtime           current mtime register value
//     cmp             current mtimecmp value (for read-back)
//     irq             registered (mtime >= mtimecmp), level-sensitive
module scr1_mtimer_cmp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  input  logic [63:0] mtime,
  output logic [63:0] cmp,
  output logic        irq
);

  // Compare register resets to all ones so no channel fires out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp <= '1;
    end else if (wr_lo) begin
      cmp[31:0] <= wdata;
    end else if (wr_hi) begin
      cmp[63:32] <= wdata;
    end
  end

  // Interrupt looks at the registered mtime/mtimecmp, so it follows a
  // change of either one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= (mtime >= cmp);
    end
  end

endmodule : scr1_mtimer_cmp

// File: rtl/scr1_mtimer_mc.sv
// scr1_mtimer_mc -- multi-channel RISC-V machine timer on the dmem bus.
//   Optional feature macro: SCR1_MTIMER_PRESCALER_EN adds a programmable
//   prescaler (DIV register); without it mtime ticks every enabled cycle
//   and DIV reads as zero.
//   Parameters:
//     SCR1_MTIMER_CH_NUM  number of compare channels (1..8)
//     SCR1_MTIMER_DIV_W   prescaler width in bits (at most 32)
//   Ports:
//     clk, rst_n                      clock, asynchronous active-low reset
//     dmem_req/cmd/width/addr/wdata   request from the dmem router
//     dmem_req_ack                    always 1, every request is accepted
//     dmem_rdata, dmem_resp           registered response, one cycle later
//     timer_irq                       per-channel compare interrupt
//     timer_val                       current mtime value
module scr1_mtimer_mc
  import scr1_memif_pkg::*;
  import scr1_mtimer_pkg::*;
#(
  parameter int SCR1_MTIMER_CH_NUM = 2,
  parameter int SCR1_MTIMER_DIV_W  = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          dmem_req,
  input  type_scr1_mem_cmd_e            dmem_cmd,
  input  type_scr1_mem_width_e          dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0]   dmem_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   dmem_wdata,
  output logic                          dmem_req_ack,
  output logic [SCR1_DMEM_DWIDTH-1:0]   dmem_rdata,
  output type_scr1_mem_resp_e           dmem_resp,
  output logic [SCR1_MTIMER_CH_NUM-1:0] timer_irq,
  output logic [63:0]                   timer_val
);

  logic [7:0]  offset;
  logic [4:0]  ch_sel;
  logic        ch_hit;
  logic        fmt_ok;
  logic        reg_ok;
  logic        acc_ok;
  logic        wr_en;
  logic [31:0] rd_data;

  logic        wr_ctrl;
  logic        wr_mtime_lo;
  logic        wr_mtime_hi;
  logic [SCR1_MTIMER_CH_NUM-1:0] cmp_wr_lo;
  logic [SCR1_MTIMER_CH_NUM-1:0] cmp_wr_hi;

  logic        ctrl_en;
  logic        tick;
  logic [63:0] mtime;
  logic [63:0] cmp_val [SCR1_MTIMER_CH_NUM];

  type_scr1_mem_resp_e resp_ff;
  logic [31:0]         rdata_ff;

  // Only the low byte selects a register; the router has already decoded
  // the rest of the address
  logic unused_addr;
  assign unused_addr = ^dmem_addr[SCR1_DMEM_AWIDTH-1:8];

  assign dmem_req_ack = 1'b1;
  assign offset       = dmem_addr[7:0];
  assign fmt_ok       = (dmem_width == SCR1_MEM_WIDTH_WORD) && (dmem_addr[1:0] == 2'b00);

  // Compare registers sit in 8-byte slots, so offset[7:3] minus the base
  // slot is the channel number and offset[2] picks the high word
  assign ch_sel = offset[7:3] - SCR1_MTIMER_OFS_CMP_BASE[7:3];
  assign ch_hit = (offset >= SCR1_MTIMER_OFS_CMP_BASE)
               && (ch_sel < 5'(SCR1_MTIMER_CH_NUM))
               && (ch_sel < 5'(SCR1_MTIMER_CH_MAX));

`ifdef SCR1_MTIMER_PRESCALER_EN
  logic [SCR1_MTIMER_DIV_W-1:0] div_val;
  logic [SCR1_MTIMER_DIV_W-1:0] presc_cnt;
  logic                         wr_div;

  assign wr_div = wr_en && (offset == SCR1_MTIMER_OFS_DIV);
  // The counter runs 0..DIV, so the period is DIV+1 cycles
  assign tick   = ctrl_en && (presc_cnt == div_val);

  // Writing DIV restarts the count so the new period takes effect cleanly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_val   <= '0;
      presc_cnt <= '0;
    end else if (wr_div) begin
      div_val   <= dmem_wdata[SCR1_MTIMER_DIV_W-1:0];
      presc_cnt <= '0;
    end else if (ctrl_en) begin
      presc_cnt <= (presc_cnt == div_val) ? '0 : presc_cnt + SCR1_MTIMER_DIV_W'(1);
    end
  end
`else
  localparam int unused_div_w = SCR1_MTIMER_DIV_W;
  assign tick = ctrl_en;
`endif

  // Register decode and read mux; reg_ok marks an offset that exists
  always_comb begin
    reg_ok  = 1'b0;
    rd_data = '0;
    case (offset)
      SCR1_MTIMER_OFS_CTRL: begin
        reg_ok = 1'b1;
        rd_data[SCR1_MTIMER_CTRL_EN] = ctrl_en;
      end
      SCR1_MTIMER_OFS_DIV: begin
        reg_ok = 1'b1;
`ifdef SCR1_MTIMER_PRESCALER_EN
        rd_data[SCR1_MTIMER_DIV_W-1:0] = div_val;
`endif
      end
      SCR1_MTIMER_OFS_MTIME_LO: begin
        reg_ok  = 1'b1;
        rd_data = mtime[31:0];
      end
      SCR1_MTIMER_OFS_MTIME_HI: begin
        reg_ok  = 1'b1;
        rd_data = mtime[63:32];
      end
      default: begin
        if (ch_hit) begin
          reg_ok = 1'b1;
          for (int i = 0; i < SCR1_MTIMER_CH_NUM; i++) begin
            if (ch_sel == 5'(i)) begin
              rd_data = offset[2] ? cmp_val[i][63:32] : cmp_val[i][31:0];
            end
          end
        end
      end
    endcase
  end

  // Rejected requests (bad width, misaligned, unmapped) never write
  assign acc_ok      = dmem_req && fmt_ok && reg_ok;
  assign wr_en       = acc_ok && (dmem_cmd == SCR1_MEM_CMD_WR);
  assign wr_ctrl     = wr_en && (offset == SCR1_MTIMER_OFS_CTRL);
  assign wr_mtime_lo = wr_en && (offset == SCR1_MTIMER_OFS_MTIME_LO);
  assign wr_mtime_hi = wr_en && (offset == SCR1_MTIMER_OFS_MTIME_HI);

  always_comb begin
    cmp_wr_lo = '0;
    cmp_wr_hi = '0;
    for (int i = 0; i < SCR1_MTIMER_CH_NUM; i++) begin
      if (wr_en && ch_hit && (ch_sel == 5'(i))) begin
        cmp_wr_lo[i] = !offset[2];
        cmp_wr_hi[i] = offset[2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en <= 1'b1;
    end else if (wr_ctrl) begin
      ctrl_en <= dmem_wdata[SCR1_MTIMER_CTRL_EN];
    end
  end

  // A software write wins over the tick: the written half loads, the
  // other half holds and the increment for this cycle is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime <= '0;
    end else if (wr_mtime_lo) begin
      mtime[31:0] <= dmem_wdata;
    end else if (wr_mtime_hi) begin
      mtime[63:32] <= dmem_wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  assign timer_val = mtime;

  for (genvar i = 0; i < SCR1_MTIMER_CH_NUM; i++) begin : g_cmp
    scr1_mtimer_cmp u_cmp (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_lo (cmp_wr_lo[i]),
      .wr_hi (cmp_wr_hi[i]),
      .wdata (dmem_wdata),
      .mtime (mtime),
      .cmp   (cmp_val[i]),
      .irq   (timer_irq[i])
    );
  end

  // Response and read data are captured in the accepting cycle; reset
  // drops any response that was still pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_ff  <= SCR1_MEM_RESP_NOTRDY;
      rdata_ff <= '0;
    end else if (dmem_req) begin
      resp_ff  <= acc_ok ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_RDY_ER;
      rdata_ff <= (acc_ok && (dmem_cmd == SCR1_MEM_CMD_RD)) ? rd_data : '0;
    end else begin
      resp_ff  <= SCR1_MEM_RESP_NOTRDY;
      rdata_ff <= '0;
    end
  end

  assign dmem_resp  = resp_ff;
  assign dmem_rdata = rdata_ff;

endmodule : scr1_mtimer_mc

// File: tb/tb_scr1_mtimer_mc.sv
// tb_scr1_mtimer_mc -- directed testbench for scr1_mtimer_mc with four
// compare channels. Expected values are hand-computed per cycle; inputs
// change and outputs are sampled 1 time unit after each rising edge.
module tb_scr1_mtimer_mc;
  import scr1_memif_pkg::*;
  import scr1_mtimer_pkg::*;

  localparam int CH_NUM = 4;

`ifdef SCR1_MTIMER_PRESCALER_EN
  localparam logic [31:0] DIV_READ = 32'd3;
  localparam logic [63:0] EXP_S3   = 64'h100;
  localparam logic [63:0] EXP_S4   = 64'h101;
  localparam logic [63:0] EXP_S8   = 64'h102;
  localparam logic [63:0] EXP_FRZ  = 64'h102;
`else
  localparam logic [31:0] DIV_READ = 32'd0;
  localparam logic [63:0] EXP_S3   = 64'h103;
  localparam logic [63:0] EXP_S4   = 64'h104;
  localparam logic [63:0] EXP_S8   = 64'h108;
  localparam logic [63:0] EXP_FRZ  = 64'h109;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 dmem_req;
  type_scr1_mem_cmd_e   dmem_cmd;
  type_scr1_mem_width_e dmem_width;
  logic [31:0]          dmem_addr;
  logic [31:0]          dmem_wdata;
  logic                 dmem_req_ack;
  logic [31:0]          dmem_rdata;
  type_scr1_mem_resp_e  dmem_resp;
  logic [CH_NUM-1:0]    timer_irq;
  logic [63:0]          timer_val;

  int errCount   = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  scr1_mtimer_mc #(
    .SCR1_MTIMER_CH_NUM (CH_NUM),
    .SCR1_MTIMER_DIV_W  (10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dmem_req     (dmem_req),
    .dmem_cmd     (dmem_cmd),
    .dmem_width   (dmem_width),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_req_ack (dmem_req_ack),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .timer_irq    (timer_irq),
    .timer_val    (timer_val)
  );

  // Single comparison point: counts every check, reports any mismatch
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus access: drive, let the edge accept it, sample the response
  task automatic applyStimulus(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e width,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output type_scr1_mem_resp_e resp, output logic [31:0] rdata);
    dmem_req   = 1'b1;
    dmem_cmd   = cmd;
    dmem_width = width;
    dmem_addr  = addr;
    dmem_wdata = wdata;
    @(posedge clk);
    #1;
    dmem_req   = 1'b0;
    dmem_wdata = '0;
    resp       = dmem_resp;
    rdata      = dmem_rdata;
  endtask

  task automatic busWrite(input string tag, input logic [31:0] addr, input logic [31:0] data);
    type_scr1_mem_resp_e r;
    logic [31:0]         d;
    applyStimulus(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, addr, data, r, d);
    checkOutput({tag, " resp"}, 64'(r), 64'(SCR1_MEM_RESP_RDY_OK));
  endtask

  task automatic busRead(input string tag, input logic [31:0] addr, input logic [31:0] expData);
    type_scr1_mem_resp_e r;
    logic [31:0]         d;
    applyStimulus(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, addr, 32'h0, r, d);
    checkOutput({tag, " resp"}, 64'(r), 64'(SCR1_MEM_RESP_RDY_OK));
    checkOutput({tag, " rdata"}, 64'(d), 64'(expData));
  endtask

  task automatic busError(input string tag, input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e width,
                          input logic [31:0] addr, input logic [31:0] data);
    type_scr1_mem_resp_e r;
    logic [31:0]         d;
    applyStimulus(cmd, width, addr, data, r, d);
    checkOutput({tag, " resp"}, 64'(r), 64'(SCR1_MEM_RESP_RDY_ER));
    checkOutput({tag, " rdata"}, 64'(d), 64'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    dmem_req   = 1'b0;
    dmem_cmd   = SCR1_MEM_CMD_RD;
    dmem_width = SCR1_MEM_WIDTH_WORD;
    dmem_addr  = '0;
    dmem_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst timer_val", timer_val, 64'h0);
    checkOutput("rst timer_irq", 64'(timer_irq), 64'h0);
    checkOutput("rst resp", 64'(dmem_resp), 64'(SCR1_MEM_RESP_NOTRDY));
    checkOutput("rst rdata", 64'(dmem_rdata), 64'h0);
    checkOutput("req_ack", 64'(dmem_req_ack), 64'h1);
    rst_n = 1'b1;

    // Free-running mtime: two reads three cycles apart, then idle response
    busRead("mtime rd1", 32'h08, 32'd0);
    nextCycle(2);
    busRead("mtime rd2", 32'h08, 32'd3);
    nextCycle(1);
    checkOutput("idle resp", 64'(dmem_resp), 64'(SCR1_MEM_RESP_NOTRDY));
    checkOutput("idle rdata", 64'(dmem_rdata), 64'h0);
    checkOutput("timer_val run", timer_val, 64'd5);
    busRead("ctrl rst", 32'h00, 32'h1);
    busRead("div rst", 32'h04, 32'h0);
    busRead("cmp0 lo rst", 32'h10, 32'hFFFF_FFFF);
    busRead("cmp3 hi rst", 32'h2C, 32'hFFFF_FFFF);

    // Carry from low to high word, then full 64-bit wrap
    busWrite("mtime lo", 32'h08, 32'hFFFF_FFFF);
    busWrite("mtime hi", 32'h0C, 32'h0);
    checkOutput("write no tick", timer_val, 64'h0000_0000_FFFF_FFFF);
    nextCycle(1);
    checkOutput("carry", timer_val, 64'h0000_0001_0000_0000);
    busWrite("mtime lo2", 32'h08, 32'hFFFF_FFFF);
    busWrite("mtime hi2", 32'h0C, 32'hFFFF_FFFF);
    checkOutput("all ones", timer_val, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("irq before eq", 64'(timer_irq), 64'h0);
    nextCycle(1);
    checkOutput("wrap", timer_val, 64'h0);
    checkOutput("irq at eq", 64'(timer_irq), 64'hF);
    nextCycle(1);
    checkOutput("irq after wrap", 64'(timer_irq), 64'h0);
    checkOutput("post wrap", timer_val, 64'h1);

    // Channel 2 compare at 0x20
    busWrite("ctrl off", 32'h00, 32'h0);
    busWrite("mtime lo0", 32'h08, 32'h0);
    busWrite("mtime hi0", 32'h0C, 32'h0);
    busWrite("cmp2 lo", 32'h20, 32'h20);
    busWrite("cmp2 hi", 32'h24, 32'h0);
    checkOutput("frozen", timer_val, 64'h0);
    checkOutput("irq idle", 64'(timer_irq), 64'h0);
    busWrite("ctrl on", 32'h00, 32'h1);
    checkOutput("start", timer_val, 64'h0);
    nextCycle(31);
    checkOutput("val 1f", timer_val, 64'h1F);
    checkOutput("irq 1f", 64'(timer_irq), 64'h0);
    nextCycle(1);
    checkOutput("val 20", timer_val, 64'h20);
    checkOutput("irq 20", 64'(timer_irq), 64'h0);
    nextCycle(1);
    checkOutput("val 21", timer_val, 64'h21);
    checkOutput("irq 21", 64'(timer_irq), 64'b0100);
    busWrite("cmp2 lo max", 32'h20, 32'hFFFF_FFFF);
    checkOutput("irq hold", 64'(timer_irq), 64'b0100);
    busWrite("cmp2 hi max", 32'h24, 32'hFFFF_FFFF);
    checkOutput("irq clear", 64'(timer_irq), 64'h0);
    busRead("cmp2 lo rd", 32'h20, 32'hFFFF_FFFF);
    busRead("cmp2 hi rd", 32'h24, 32'hFFFF_FFFF);

    // Error responses leave the registers alone
    busWrite("ctrl off2", 32'h00, 32'h0);
    busWrite("mtime lo100", 32'h08, 32'h100);
    busWrite("mtime hi100", 32'h0C, 32'h0);
    busRead("mtime lo rd", 32'h08, 32'h100);
    busError("rd ch4", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h30, 32'h0);
    busError("rd hword", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h08, 32'h0);
    busError("rd misalign", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h09, 32'h0);
    busError("rd unmapped", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'hFC, 32'h0);
    busError("wr ch4", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h30, 32'h55);
    busError("wr hword", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h08, 32'hDEAD);
    busError("wr misalign", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h09, 32'hBEEF);
    checkOutput("err no change", timer_val, 64'h100);
    busRead("cmp0 lo keep", 32'h10, 32'hFFFF_FFFF);
    busRead("ctrl keep", 32'h00, 32'h0);

    // Prescaler (or its absence) and enable freeze
    busWrite("div wr", 32'h04, 32'h3);
    busRead("div rd", 32'h04, DIV_READ);
    busWrite("ctrl run", 32'h00, 32'h1);
    nextCycle(3);
    checkOutput("presc s3", timer_val, EXP_S3);
    nextCycle(1);
    checkOutput("presc s4", timer_val, EXP_S4);
    nextCycle(4);
    checkOutput("presc s8", timer_val, EXP_S8);
    busWrite("ctrl stop", 32'h00, 32'h0);
    nextCycle(10);
    checkOutput("freeze", timer_val, EXP_FRZ);

    // Reset in the middle of an outstanding request
    busWrite("mtime lo1234", 32'h08, 32'h1234);
    busWrite("mtime hi1234", 32'h0C, 32'h0);
    busWrite("cmp0 lo0", 32'h10, 32'h0);
    busWrite("cmp0 hi0", 32'h14, 32'h0);
    nextCycle(1);
    checkOutput("pre-rst irq", 64'(timer_irq), 64'b0001);
    checkOutput("pre-rst val", timer_val, 64'h1234);
    dmem_req   = 1'b1;
    dmem_cmd   = SCR1_MEM_CMD_RD;
    dmem_width = SCR1_MEM_WIDTH_WORD;
    dmem_addr  = 32'h08;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid-rst val", timer_val, 64'h0);
    checkOutput("mid-rst irq", 64'(timer_irq), 64'h0);
    checkOutput("mid-rst resp", 64'(dmem_resp), 64'(SCR1_MEM_RESP_NOTRDY));
    @(posedge clk);
    #1;
    dmem_req = 1'b0;
    rst_n    = 1'b1;
    checkOutput("rst held resp", 64'(dmem_resp), 64'(SCR1_MEM_RESP_NOTRDY));
    nextCycle(1);
    checkOutput("post-rst resp", 64'(dmem_resp), 64'(SCR1_MEM_RESP_NOTRDY));
    checkOutput("post-rst rdata", 64'(dmem_rdata), 64'h0);
    checkOutput("post-rst val", timer_val, 64'h1);
    checkOutput("post-rst irq", 64'(timer_irq), 64'h0);
    busRead("post-rst ctrl", 32'h00, 32'h1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule : tb_scr1_mtimer_mc
